// File: rtl/count_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : count_ctrl_pkg
// Brief    : Shared state encoding and defaults for count_controller.
// Revision : 1.0
// ============================================================================
package count_ctrl_pkg;

  localparam int DEFAULT_REPEAT_W = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/count_controller.sv
`default_nettype none
// ============================================================================
// Module   : count_controller
// Brief    : Sequences load/enable/direction of an up/down counter for one or
//            more passes. Optional pause support under COUNT_CTRL_PAUSE_EN.
// Revision : 1.0
// ============================================================================
module count_controller
  import count_ctrl_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int REPEAT_W = DEFAULT_REPEAT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                pause,
  input  logic [WIDTH-1:0]    cfg_value,
  input  logic                cfg_dir,
  input  logic [REPEAT_W-1:0] cfg_repeat,
  output logic                busy,
  output logic                done_pulse,
  output logic [REPEAT_W-1:0] pass_count,
  output logic                cnt_load,
  output logic [WIDTH-1:0]    cnt_load_value,
  output logic                cnt_enable,
  output logic                cnt_direction,
  input  logic [WIDTH-1:0]    cnt_value,
  input  logic                cnt_done
);

  state_e              state_q, state_d;
  logic [REPEAT_W-1:0] remaining_q, remaining_d;
  logic [REPEAT_W-1:0] pass_count_q, pass_count_d;
  logic [WIDTH-1:0]    load_value_q, load_value_d;
  logic                direction_q, direction_d;
  logic                busy_q, busy_d;
  logic                done_pulse_q, done_pulse_d;
  logic                load_q, load_d;
  logic                pause_eff;
  logic                unused_inputs;

`ifdef COUNT_CTRL_PAUSE_EN
  assign pause_eff     = pause;
  assign unused_inputs = ^cnt_value;
`else
  assign pause_eff     = 1'b0;
  assign unused_inputs = ^{pause, cnt_value};
`endif

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    pass_count_d = pass_count_q;
    load_value_d = load_value_q;
    direction_d  = direction_q;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          load_value_d = cfg_value;
          direction_d  = cfg_dir;
          remaining_d  = cfg_repeat;
          pass_count_d = '0;
          state_d      = LOAD;
        end
      end
      LOAD:  state_d = stop ? IDLE : RUN;
      RUN: begin
        // Terminal flag outranks pause; stop outranks everything.
        if (stop) begin
          state_d = IDLE;
        end else if (cnt_done) begin
          if (pass_count_q != '1) pass_count_d = pass_count_q + 1'b1;
          if (remaining_q != '0) begin
            remaining_d = remaining_q - 1'b1;
            state_d     = LOAD;
          end else begin
            state_d = DONE;
          end
        end else if (pause_eff) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (stop)            state_d = IDLE;
        else if (!pause_eff) state_d = RUN;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d       = (state_d == LOAD) || (state_d == RUN) || (state_d == PAUSE);
    done_pulse_d = (state_d == DONE);
    load_d       = (state_d == LOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      pass_count_q <= '0;
      load_value_q <= '0;
      direction_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_pulse_q <= 1'b0;
      load_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      pass_count_q <= pass_count_d;
      load_value_q <= load_value_d;
      direction_q  <= direction_d;
      busy_q       <= busy_d;
      done_pulse_q <= done_pulse_d;
      load_q       <= load_d;
    end
  end

  // Enable follows cnt_done combinationally so the counter stops on terminal.
  assign cnt_enable     = (state_q == RUN) && !cnt_done && !stop && !pause_eff;
  assign cnt_load       = load_q && !stop;
  assign busy           = busy_q;
  assign done_pulse     = done_pulse_q;
  assign pass_count     = pass_count_q;
  assign cnt_load_value = load_value_q;
  assign cnt_direction  = direction_q;

endmodule
`default_nettype wire

// File: tb/tb_count_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_controller
// Brief    : Directed bench for count_controller driving a behavioural counter.
// Revision : 1.0
// ============================================================================
module tb_count_controller;

  localparam int WIDTH    = 8;
  localparam int REPEAT_W = 4;
  localparam int RUN_CYC  = 30;

  logic                clk = 1'b0;
  logic                rst, start, stop, pause, cfg_dir;
  logic [WIDTH-1:0]    cfg_value;
  logic [REPEAT_W-1:0] cfg_repeat;
  logic                busy, done_pulse, cnt_load, cnt_enable, cnt_direction, cnt_done;
  logic [REPEAT_W-1:0] pass_count;
  logic [WIDTH-1:0]    cnt_load_value, cnt_value, ctr_q;

  count_controller #(.WIDTH(WIDTH), .REPEAT_W(REPEAT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .cfg_value(cfg_value), .cfg_dir(cfg_dir), .cfg_repeat(cfg_repeat),
    .busy(busy), .done_pulse(done_pulse), .pass_count(pass_count),
    .cnt_load(cnt_load), .cnt_load_value(cnt_load_value),
    .cnt_enable(cnt_enable), .cnt_direction(cnt_direction),
    .cnt_value(cnt_value), .cnt_done(cnt_done)
  );

  always #5 clk = ~clk;

  // Counter being driven.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             ctr_q <= '0;
    else if (cnt_load)   ctr_q <= cnt_load_value;
    else if (cnt_enable) ctr_q <= cnt_direction ? ctr_q + 8'd1 : ctr_q - 8'd1;
  end
  assign cnt_value = ctr_q;
  assign cnt_done  = cnt_direction ? (ctr_q == 8'hFF) : (ctr_q == 8'h00);

  typedef struct {
    int done_cyc; int n_done; int loads; int enables;
    int passes; int value; int stride;
  } exp_t;

  exp_t sb[$];
  int   cyc, n_load, n_en, n_done, done_cyc;
  int   load_cyc[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always @(negedge clk) begin
    if (cnt_load) begin
      n_load++;
      load_cyc.push_back(cyc);
    end
    if (cnt_enable) n_en++;
    if (done_pulse) begin
      n_done++;
      if (done_cyc < 0) done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".busy"},       int'(busy), 0);
    check({tag, ".done"},       int'(done_pulse), 0);
    check({tag, ".pass"},       int'(pass_count), 0);
    check({tag, ".load"},       int'(cnt_load), 0);
    check({tag, ".enable"},     int'(cnt_enable), 0);
    check({tag, ".load_value"}, int'(cnt_load_value), 0);
    check({tag, ".dir"},        int'(cnt_direction), 0);
  endtask

  // Reference timing: V enable cycles per pass, V+2 cycles per pass.
  function automatic exp_t model(input int v, input int dir, input int rep);
    exp_t e;
    int vp;
    vp         = dir ? ((1 << WIDTH) - 1 - v) : v;
    e.stride   = vp + 2;
    e.done_cyc = 1 + (rep + 1) * (vp + 2);
    e.n_done   = 1;
    e.loads    = rep + 1;
    e.enables  = (rep + 1) * vp;
    e.passes   = rep + 1;
    e.value    = dir ? (1 << WIDTH) - 1 : 0;
    return e;
  endfunction

  task automatic run(input int v, input int dir, input int rep, input int stop_c,
                     input int rst_c, input int p_lo, input int p_hi, input int start2_c,
                     input int probe_c, input int probe_v);
    cfg_value  = WIDTH'(v);
    cfg_dir    = dir[0];
    cfg_repeat = REPEAT_W'(rep);
    n_load = 0; n_en = 0; n_done = 0; done_cyc = -1;
    load_cyc.delete();
    for (int c = 0; c < RUN_CYC; c++) begin
      cyc   = c;
      start = (c == 0) || (c == start2_c);
      stop  = (c == stop_c);
      rst   = (c == rst_c);
      pause = (c >= p_lo) && (c <= p_hi);
      if (c == rst_c) begin
        #1;
        check_reset("midrun_rst");
      end
      if (c == probe_c) begin
        #1;
        check("probe_value", int'(cnt_value), probe_v);
      end
      @(posedge clk);
      #1;
    end
    start = 0; stop = 0; rst = 0; pause = 0;
  endtask

  task automatic verify(input string tag);
    exp_t e;
    e = sb.pop_front();
    check({tag, ".done_cyc"}, done_cyc, e.done_cyc);
    check({tag, ".n_done"},   n_done,   e.n_done);
    check({tag, ".loads"},    n_load,   e.loads);
    check({tag, ".enables"},  n_en,     e.enables);
    check({tag, ".pass"},     int'(pass_count), e.passes);
    check({tag, ".value"},    int'(cnt_value),  e.value);
    check({tag, ".busy"},     int'(busy), 0);
    for (int i = 0; i < load_cyc.size() && i < e.loads; i++)
      check({tag, ".load_cyc"}, load_cyc[i], 1 + i * e.stride);
  endtask

  initial begin
    exp_t e;
    rst = 1; start = 0; stop = 0; pause = 0;
    cfg_value = '0; cfg_dir = 0; cfg_repeat = '0; cyc = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 0;
    @(posedge clk);
    #1;

    sb.push_back(model(5, 0, 0));
    run(5, 0, 0, -1, -1, -1, -2, -1, -1, 0);
    verify("down5");

    sb.push_back(model(250, 1, 2));
    run(250, 1, 2, -1, -1, -1, -2, -1, -1, 0);
    verify("up250x3");

    sb.push_back(model(0, 0, 0));
    run(0, 0, 0, -1, -1, -1, -2, -1, -1, 0);
    verify("zero_len");

    sb.push_back(model(5, 0, 0));
    run(5, 0, 0, -1, -1, -1, -2, 4, -1, 0);
    verify("start_in_run");

    // start with stop in IDLE: nothing happens, previous results hold.
    e = '{done_cyc: -1, n_done: 0, loads: 0, enables: 0, passes: 1, value: 0, stride: 7};
    sb.push_back(e);
    run(9, 0, 0, 0, -1, -1, -2, -1, 1, 0);
    verify("start_stop_idle");

    e = '{done_cyc: -1, n_done: 0, loads: 1, enables: 2, passes: 0, value: 3, stride: 7};
    sb.push_back(e);
    run(5, 0, 0, 4, -1, -1, -2, -1, 5, 3);
    verify("stop_c4");

    e = '{done_cyc: -1, n_done: 0, loads: 1, enables: 2, passes: 0, value: 0, stride: 7};
    sb.push_back(e);
    run(5, 0, 0, -1, 4, -1, -2, -1, -1, 0);
    verify("rst_c4");

    e = model(5, 0, 0);
`ifdef COUNT_CTRL_PAUSE_EN
    e.done_cyc = 12;
    sb.push_back(e);
    run(5, 0, 0, -1, -1, 3, 5, -1, 5, 4);
`else
    sb.push_back(e);
    run(5, 0, 0, -1, -1, 3, 5, -1, 5, 2);
`endif
    verify("pause_c3_5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
